// File: rtl/sel_rotator_pkg.sv
// sel_rotator_pkg: shared widths, direction codes and character-word field positions
package sel_rotator_pkg;
    localparam int SEL_W  = 2;
    localparam int CHAR_W = 2;
    localparam int WORD_W = 8;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    localparam int U_LSB = 0;
    localparam int V_LSB = 2;
    localparam int W_LSB = 4;
    localparam int X_LSB = 6;
endpackage

// File: rtl/sel_rotator_tick_prescaler.sv
// tick_prescaler: counts enabled cycles and raises tick on the last one of every DIV
module tick_prescaler #(
    parameter int DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // tick is the wrap cycle; it is qualified by enable so a paused counter never fires
    always_comb tick = enable && (count == LAST);

    // count holds while paused; clear (load) and reset discard any partial interval
    always_ff @(posedge clock)
        if (reset || clear) count <= '0;
        else if (enable) count <= (count == LAST) ? '0 : count + CW'(1);
endmodule

// File: rtl/sel_rotator.sv
// sel_rotator: drives the shared 4:1 mux select and the four character codes for scrolling displays
module sel_rotator
    import sel_rotator_pkg::*;
#(
    parameter int                DIV        = 50_000_000,
    parameter logic [WORD_W-1:0] RESET_WORD = 8'b11100100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              step,
    input  logic              dir,
    input  logic              load,
    input  logic [WORD_W-1:0] chars_in,
    output logic [SEL_W-1:0]  s,
    output logic [CHAR_W-1:0] u,
    output logic [CHAR_W-1:0] v,
    output logic [CHAR_W-1:0] w,
    output logic [CHAR_W-1:0] x,
    output logic              advance
);
    logic [WORD_W-1:0] word;
    logic              step_q;
    logic              tick;
    logic              step_rise;
    logic              req;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (load),
        .enable(enable),
        .tick  (tick)
    );

    // a step press only counts while paused; in run mode the prescaler owns rotation
    always_comb begin
        step_rise = step & ~step_q;
        req       = tick | (step_rise & ~enable);
    end

    // load outranks rotate; every output comes straight from a register
    always_ff @(posedge clock)
        if (reset) begin
            s       <= '0;
            word    <= RESET_WORD;
            advance <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step;
            if (load) begin
                word    <= chars_in;
                s       <= '0;
                advance <= 1'b0;
            end else begin
                s       <= req ? ((dir == DIR_DOWN) ? s - SEL_W'(1) : s + SEL_W'(1)) : s;
                advance <= req;
            end
        end

    assign u = word[U_LSB +: CHAR_W];
    assign v = word[V_LSB +: CHAR_W];
    assign w = word[W_LSB +: CHAR_W];
    assign x = word[X_LSB +: CHAR_W];
endmodule

// File: tb/tb_sel_rotator.sv
// tb_sel_rotator: random and directed stimulus checked against a behavioural display-rotation model
module tb_sel_rotator;
    localparam int DIV = 4;

    logic       clk = 0;
    logic       rst = 1;
    logic       enable = 0;
    logic       step = 0;
    logic       dir = 0;
    logic       load = 0;
    logic [7:0] chars_in = 0;
    logic [1:0] s, u, v, w, x;
    logic       advance;

    int n_chk = 0;
    int n_fail = 0;

    int       m_s, m_cnt;
    bit [7:0] m_word;
    bit       m_adv, m_step_prev;

    sel_rotator #(.DIV(DIV), .RESET_WORD(8'hE4)) dut (
        .clock(clk), .reset(rst), .enable(enable), .step(step), .dir(dir),
        .load(load), .chars_in(chars_in), .s(s), .u(u), .v(v), .w(w), .x(x),
        .advance(advance)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: advance the model from the inputs held across the edge, then compare
    task automatic cycle();
        bit press, fire;
        @(posedge clk);
        if (rst) begin
            m_s = 0; m_word = 8'hE4; m_cnt = 0; m_adv = 0; m_step_prev = 0;
        end else begin
            press = step && !m_step_prev;
            fire  = (enable && m_cnt == DIV - 1) || (press && !enable);
            if (load) begin
                m_word = chars_in; m_s = 0; m_cnt = 0; m_adv = 0;
            end else begin
                if (enable) m_cnt = (m_cnt + 1) % DIV;
                if (fire) m_s = (m_s + (dir ? 3 : 1)) % 4;
                m_adv = fire;
            end
            m_step_prev = step;
        end
        #1;
        chk("s", s, m_s);
        chk("word", {x, w, v, u}, m_word);
        chk("advance", advance, m_adv);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int k;
        cycles(2);
        rst = 0;
        cycles(20);
        chk("reset_s", s, 0);
        chk("reset_word", {x, w, v, u}, 8'hE4);

        enable = 1;
        cycles(3);
        chk("no_early_adv", advance, 0);
        cycle();
        chk("first_adv", advance, 1);
        chk("first_s", s, 1);
        cycles(16);
        chk("run_s_after_5", s, 1);

        cycles(2);
        enable = 0;
        cycles(10);
        enable = 1;
        cycle();
        chk("held_no_adv", advance, 0);
        cycle();
        chk("held_adv", advance, 1);
        chk("held_s", s, 2);

        enable = 0; load = 1; chars_in = 8'hE4;
        cycle();
        load = 0; dir = 1; step = 1;
        cycles(5);
        step = 0;
        cycles(2);
        chk("step_down_s", s, 3);
        step = 1; cycles(2); step = 0; cycles(2);
        chk("step_down_s2", s, 2);
        enable = 1; step = 1; cycles(2); step = 0; cycles(2);

        dir = 0;
        k = 0;
        while (k < 32 && m_cnt != DIV - 1) begin cycle(); k++; end
        chk("reach_last", m_cnt, DIV - 1);
        load = 1; chars_in = 8'h1B;
        cycle();
        load = 0;
        chk("load_s", s, 0);
        chk("load_word", {x, w, v, u}, 8'h1B);
        chk("load_adv", advance, 0);
        cycles(3);
        cycle();
        chk("post_load_adv", advance, 1);

        k = 0;
        while (k < 64 && !(m_s == 2 && m_cnt == 3)) begin cycle(); k++; end
        chk("reach_mid", {m_s[1:0], m_cnt[1:0]}, 4'b1011);
        rst = 1;
        cycle();
        chk("midrst_s", s, 0);
        chk("midrst_word", {x, w, v, u}, 8'hE4);
        chk("midrst_adv", advance, 0);
        rst = 0;
        cycles(4);
        chk("resume_adv", advance, 1);

        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(99) == 0);
            enable   = ($urandom_range(3) != 0);
            step     = $urandom_range(1);
            dir      = $urandom_range(1);
            load     = ($urandom_range(19) == 0);
            chars_in = 8'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
